// File: rtl/cond_seq.sv
// Multicycle conditional-execution sequencer: evaluates Cond against NZCV, waits EXEC_CYCLES, then issues gated commit strobes.
// Optional COND_SEQ_PIPE_EN lets a new instruction be accepted during COMMIT and go straight to EVAL.
module cond_seq #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [3:0] Cond,
  input  logic [1:0] FlagW,
  input  logic       NoWrite,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic [3:0] ALUFlags,
  output logic [3:0] Flags,
  output logic       CondEx,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       done,
  output logic [1:0] state
);

  localparam int CW = $clog2(EXEC_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_EVAL   = 2'b01,
    S_EXEC   = 2'b10,
    S_COMMIT = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cond_q, cond_d;
  logic [1:0]    flagw_q, flagw_d;
  logic          nowrite_q, nowrite_d;
  logic          pcs_q, pcs_d;
  logic          regw_q, regw_d;
  logic          memw_q, memw_d;
  logic          condex_q, condex_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    alu_q, alu_d;
  logic [3:0]    flags_q, flags_d;

  logic          xfer;
  logic          cnt_zero;

  // Flags are {N,Z,C,V}; encoding 1111 is forced to 0 so the result is never X.
  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, ge;
    n  = f[3];
    z  = f[2];
    cf = f[1];
    v  = f[0];
    ge = (n == v);
    case (c)
      4'b0000: cond_eval = z;
      4'b0001: cond_eval = ~z;
      4'b0010: cond_eval = cf;
      4'b0011: cond_eval = ~cf;
      4'b0100: cond_eval = n;
      4'b0101: cond_eval = ~n;
      4'b0110: cond_eval = v;
      4'b0111: cond_eval = ~v;
      4'b1000: cond_eval = cf & ~z;
      4'b1001: cond_eval = ~(cf & ~z);
      4'b1010: cond_eval = ge;
      4'b1011: cond_eval = ~ge;
      4'b1100: cond_eval = ~z & ge;
      4'b1101: cond_eval = ~(~z & ge);
      4'b1110: cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  assign xfer     = instr_valid & instr_ready;
  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cond_q    <= '0;
      flagw_q   <= '0;
      nowrite_q <= 1'b0;
      pcs_q     <= 1'b0;
      regw_q    <= 1'b0;
      memw_q    <= 1'b0;
      condex_q  <= 1'b0;
      cnt_q     <= '0;
      alu_q     <= '0;
      flags_q   <= '0;
    end else begin
      state_q   <= state_d;
      cond_q    <= cond_d;
      flagw_q   <= flagw_d;
      nowrite_q <= nowrite_d;
      pcs_q     <= pcs_d;
      regw_q    <= regw_d;
      memw_q    <= memw_d;
      condex_q  <= condex_d;
      cnt_q     <= cnt_d;
      alu_q     <= alu_d;
      flags_q   <= flags_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (xfer) state_d = S_EVAL;
      S_EVAL:   state_d = S_EXEC;
      S_EXEC:   if (cnt_zero) state_d = S_COMMIT;
      S_COMMIT: begin
`ifdef COND_SEQ_PIPE_EN
        state_d = xfer ? S_EVAL : S_IDLE;
`else
        state_d = S_IDLE;
`endif
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath: instruction capture, condition register, counter, flag latch and commit.
  always_comb begin
    cond_d    = cond_q;
    flagw_d   = flagw_q;
    nowrite_d = nowrite_q;
    pcs_d     = pcs_q;
    regw_d    = regw_q;
    memw_d    = memw_q;
    condex_d  = condex_q;
    cnt_d     = cnt_q;
    alu_d     = alu_q;
    flags_d   = flags_q;

    if (xfer) begin
      cond_d    = Cond;
      flagw_d   = FlagW;
      nowrite_d = NoWrite;
      pcs_d     = PCS;
      regw_d    = RegW;
      memw_d    = MemW;
    end

    case (state_q)
      S_EVAL: begin
        condex_d = cond_eval(cond_q, flags_q);
        cnt_d    = CW'(EXEC_CYCLES - 1);
      end
      S_EXEC: begin
        if (cnt_zero) alu_d = ALUFlags;
        else          cnt_d = cnt_q - CW'(1);
      end
      S_COMMIT: begin
        // Written at the exit edge so a pipelined follower's EVAL sees them.
        if (condex_q) begin
          if (flagw_q[1]) flags_d[3:2] = alu_q[3:2];
          if (flagw_q[0]) flags_d[1:0] = alu_q[1:0];
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    instr_ready = 1'b0;
    done        = 1'b0;
    PCWrite     = 1'b0;
    RegWrite    = 1'b0;
    MemWrite    = 1'b0;
    case (state_q)
      S_IDLE:   instr_ready = 1'b1;
      S_COMMIT: begin
`ifdef COND_SEQ_PIPE_EN
        instr_ready = 1'b1;
`endif
        done     = ~reset;
        PCWrite  = ~reset & pcs_q & condex_q;
        RegWrite = ~reset & regw_q & condex_q & ~nowrite_q;
        MemWrite = ~reset & memw_q & condex_q;
      end
      default: ;
    endcase
  end

  assign Flags  = flags_q;
  assign CondEx = condex_q;
  assign state  = state_q;

endmodule

// File: tb/tb_cond_seq.sv
// Directed bench for cond_seq: one instance with EXEC_CYCLES=1 and one with EXEC_CYCLES=4.
module tb_cond_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset1, reset4, valid1, valid4;
  logic [3:0] cond;
  logic [1:0] flagw;
  logic       nowrite, pcs, regw, memw;
  logic [3:0] alu1, alu4;

  logic       ready1, condex1, pcw1, rw1, mw1, done1;
  logic [3:0] flags1;
  logic [1:0] state1;
  logic       ready4, condex4, pcw4, rw4, mw4, done4;
  logic [3:0] flags4;
  logic [1:0] state4;

  int total = 0;
  int bad   = 0;

  cond_seq #(.EXEC_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset1), .instr_valid(valid1), .instr_ready(ready1),
    .Cond(cond), .FlagW(flagw), .NoWrite(nowrite), .PCS(pcs), .RegW(regw), .MemW(memw),
    .ALUFlags(alu1), .Flags(flags1), .CondEx(condex1), .PCWrite(pcw1),
    .RegWrite(rw1), .MemWrite(mw1), .done(done1), .state(state1)
  );

  cond_seq #(.EXEC_CYCLES(4)) dut4 (
    .clk(clk), .reset(reset4), .instr_valid(valid4), .instr_ready(ready4),
    .Cond(cond), .FlagW(flagw), .NoWrite(nowrite), .PCS(pcs), .RegW(regw), .MemW(memw),
    .ALUFlags(alu4), .Flags(flags4), .CondEx(condex4), .PCWrite(pcw4),
    .RegWrite(rw4), .MemWrite(mw4), .done(done4), .state(state4)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one instruction to dut1 and returns sampled inside its COMMIT cycle.
  task automatic run1(input string tag, input logic [3:0] c, input logic [1:0] fw,
                      input logic nw, input logic p, input logic r, input logic m,
                      input logic [3:0] a);
    int cyc;
    cond = c; flagw = fw; nowrite = nw; pcs = p; regw = r; memw = m;
    alu1 = ~a;
    valid1 = 1'b1;
    step();
    valid1 = 1'b0;
    cond = ~c; flagw = ~fw; nowrite = ~nw; pcs = ~p; regw = ~r; memw = ~m;
    cyc = 1;
    while (state1 != 2'b11 && cyc < 20) begin
      alu1 = (cyc == 2) ? a : ~a;
      step();
      cyc++;
    end
    alu1 = ~a;
    chk({tag, ".commit_cycle"}, cyc, 3);
    chk({tag, ".done"}, int'(done1), 1);
  endtask

  logic [15:0] cond_tab;
  int          dc[8];
  logic        dcx[8];
  logic        drw[8];
  int          nd;
  int          k;
  int          per;
  int          cyc4;

  initial begin
    reset1 = 1'b1; reset4 = 1'b1; valid1 = 1'b0; valid4 = 1'b0;
    cond = '0; flagw = '0; nowrite = 1'b0; pcs = 1'b0; regw = 1'b0; memw = 1'b0;
    alu1 = '0; alu4 = '0;
    step();
    step();
    chk("rst.state", int'(state1), 0);
    chk("rst.flags", int'(flags1), 0);
    chk("rst.condex", int'(condex1), 0);
    chk("rst.ready", int'(ready1), 1);
    chk("rst.strobes", int'({done1, pcw1, rw1, mw1}), 0);
    chk("rst.flags4", int'(flags4), 0);
    reset1 = 1'b0; reset4 = 1'b0;
    step();

    run1("al_fw11", 4'b1110, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100);
    step();
    chk("al_fw11.flags", int'(flags1), 'b0100);
    chk("al_fw11.idle", int'(state1), 0);

    run1("eq", 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
    chk("eq.regwrite", int'(rw1), 1);
    chk("eq.condex", int'(condex1), 1);
    step();

    run1("ne", 4'b0001, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111);
    chk("ne.regwrite", int'(rw1), 0);
    chk("ne.condex", int'(condex1), 0);
    step();
    chk("ne.flags", int'(flags1), 'b0100);

    run1("clr", 4'b1110, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    step();
    chk("clr.flags", int'(flags1), 0);
    run1("part", 4'b1110, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111);
    step();
    chk("part.flags", int'(flags1), 'b1100);

    run1("nowr", 4'b1110, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0000);
    chk("nowr.regwrite", int'(rw1), 0);
    chk("nowr.pcwrite", int'(pcw1), 1);
    chk("nowr.memwrite", int'(mw1), 1);
    step();
    chk("nowr.strobes_after", int'({done1, pcw1, rw1, mw1}), 0);

    run1("nv", 4'b1111, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0101);
    chk("nv.condex", int'(condex1), 0);
    chk("nv.strobes", int'({pcw1, rw1, mw1}), 0);
    step();
    chk("nv.flags", int'(flags1), 'b1100);

    // Flags N=1 Z=1 C=0 V=0: expected result for every encoding, bit i = Cond i.
    cond_tab = 16'h6A99;
    for (int i = 0; i < 16; i++) begin
      run1($sformatf("cond%0d", i), 4'(i), 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
      chk($sformatf("cond%0d.condex", i), int'(condex1), int'(cond_tab[i]));
      step();
    end

    // Valid held high: alternating flag-clearing AL and GT with RegW.
    for (int i = 0; i < 8; i++) begin dc[i] = -1; dcx[i] = 1'b0; drw[i] = 1'b0; end
    nd = 0; k = 0;
    alu1 = 4'b0000;
    for (int c = 0; c < 16; c++) begin
      if (done1 && nd < 8) begin
        dc[nd] = c; dcx[nd] = condex1; drw[nd] = rw1; nd++;
      end
      if (ready1) begin
        if (k % 2 == 0) begin cond = 4'b1110; flagw = 2'b11; regw = 1'b0; end
        else            begin cond = 4'b1100; flagw = 2'b00; regw = 1'b1; end
        nowrite = 1'b0; pcs = 1'b0; memw = 1'b0;
        k++;
      end
      valid1 = 1'b1;
      step();
    end
    valid1 = 1'b0;
`ifdef COND_SEQ_PIPE_EN
    per = 3;
`else
    per = 4;
`endif
    chk("tput.first_done", dc[0], 3);
    chk("tput.period1", dc[1] - dc[0], per);
    chk("tput.period2", dc[2] - dc[1], per);
    chk("tput.gt_condex", int'(dcx[1]), 1);
    chk("tput.gt_regwrite", int'(drw[1]), 1);
    chk("tput.al_regwrite", int'(drw[0]), 0);
    for (int i = 0; i < 6; i++) step();
    chk("tput.drained", int'(state1), 0);

    // EXEC_CYCLES=4: reset in COMMIT drops the instruction.
    cond = 4'b1110; flagw = 2'b11; nowrite = 1'b0; pcs = 1'b1; regw = 1'b1; memw = 1'b1;
    alu4 = 4'b0110;
    valid4 = 1'b1;
    step();
    valid4 = 1'b0;
    cyc4 = 1;
    while (state4 != 2'b11 && cyc4 < 30) begin
      alu4 = (cyc4 == 5) ? 4'b1001 : 4'b0110;
      step();
      cyc4++;
    end
    alu4 = 4'b0110;
    chk("x4a.commit_cycle", cyc4, 6);
    chk("x4a.done", int'(done4), 1);
    chk("x4a.pcwrite", int'(pcw4), 1);
    reset4 = 1'b1;
    #1;
    chk("x4a.rst_strobes", int'({done4, pcw4, rw4, mw4}), 0);
    step();
    reset4 = 1'b0;
    chk("x4a.rst_flags", int'(flags4), 0);
    chk("x4a.rst_state", int'(state4), 0);

    // Same instruction without reset: flags come from the last EXEC cycle only.
    valid4 = 1'b1;
    step();
    valid4 = 1'b0;
    cyc4 = 1;
    while (state4 != 2'b11 && cyc4 < 30) begin
      alu4 = (cyc4 == 5) ? 4'b1001 : 4'b0110;
      step();
      cyc4++;
    end
    alu4 = 4'b0110;
    chk("x4b.commit_cycle", cyc4, 6);
    chk("x4b.strobes", int'({done4, pcw4, rw4, mw4}), 'b1111);
    step();
    chk("x4b.flags", int'(flags4), 'b1001);
    chk("x4b.strobes_after", int'({done4, pcw4, rw4, mw4}), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
